seg7_scan_mux: RTL and testbench

Time-multiplexed scan controller for a 4-digit common-anode 7-segment display. It holds a frame-coherent copy of a 16-bit hex/BCD value plus decimal points and presents one nibble at a time on bcd to the downstream bcd7seg-style decoder. It drives the active-low digit anodes and decimal point, with a blanking gap between digits to prevent ghosting. New values are accepted at any time but applied only at a frame boundary, so the display never tears.

---
 rtl/seg7_scan_mux.sv | 168 ++++++++++++++++
 tb/tb_seg7_scan_mux.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_mux.sv
// rtl/seg7_scan_mux.sv - 4-digit common-anode 7-segment scan controller with frame-coherent loads
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1.
module seg7_scan_mux #(
  parameter int PRESCALE  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        load,
  output logic        load_pend,
  output logic [3:0]  bcd,
  output logic [3:0]  an,
  output logic        dp_n,
  output logic        frame_tick
);

  localparam int CMAX = (PRESCALE > BLANK_CYC) ? PRESCALE : BLANK_CYC;
  localparam int CW   = (CMAX > 0) ? $clog2(CMAX + 1) : 1;
  localparam logic [CW-1:0] P_LAST = CW'(PRESCALE);
  localparam logic [CW-1:0] B_LAST = CW'(BLANK_CYC);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  typedef enum logic {S_GAP, S_DRIVE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   shadow_val_q, shadow_val_d;
  logic [3:0]    shadow_dp_q, shadow_dp_d;
  logic [15:0]   pend_val_q, pend_val_d;
  logic [3:0]    pend_dp_q, pend_dp_d;
  logic          load_pend_q, load_pend_d;
  logic [3:0]    an_q, an_d;
  logic [3:0]    bcd_q, bcd_d;
  logic          dp_n_q, dp_n_d;
  logic          tick_q, tick_d;
  logic          boundary;
  logic          lz_blank;
  logic [3:0]    nib_d;

  // Counters are 1-based within a phase: reset value 0 makes the first edge begin GAP.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    boundary = 1'b0;
    case (state_q)
      S_GAP: begin
        if (BLANK_CYC == 0 || cnt_q == B_LAST) begin
          state_d = S_DRIVE;
          cnt_d   = C_ONE;
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end
      default: begin
        if (cnt_q == P_LAST) begin
          idx_d    = idx_q + 2'd1;
          boundary = (idx_q == 2'd3);
          if (BLANK_CYC == 0) begin
            state_d = S_DRIVE;
            cnt_d   = C_ONE;
          end else begin
            state_d = S_GAP;
            cnt_d   = (cnt_q == B_LAST) ? C_ONE : C_ONE;
          end
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end
    endcase
  end

  always_comb begin
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    load_pend_d  = load_pend_q;
    tick_d       = boundary;
    if (boundary) begin
      load_pend_d = 1'b0;
      if (load) begin
        shadow_val_d = value;
        shadow_dp_d  = dp_in;
      end else if (load_pend_q) begin
        shadow_val_d = pend_val_q;
        shadow_dp_d  = pend_dp_q;
      end
    end else if (load) begin
      pend_val_d  = value;
      pend_dp_d   = dp_in;
      load_pend_d = 1'b1;
    end
  end

  always_comb begin
    case (idx_d)
      2'd0:    nib_d = shadow_val_d[3:0];
      2'd1:    nib_d = shadow_val_d[7:4];
      2'd2:    nib_d = shadow_val_d[11:8];
      default: nib_d = shadow_val_d[15:12];
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    case (idx_d)
      2'd3:    lz_blank = (shadow_val_d[15:12] == 4'h0) && !shadow_dp_d[3];
      2'd2:    lz_blank = (shadow_val_d[15:8] == 8'h00) && !shadow_dp_d[2];
      2'd1:    lz_blank = (shadow_val_d[15:4] == 12'h000) && !shadow_dp_d[1];
      default: lz_blank = 1'b0;
    endcase
  end
`else
  assign lz_blank = 1'b0;
`endif

  always_comb begin
    an_d   = 4'b1111;
    bcd_d  = 4'hF;
    dp_n_d = 1'b1;
    if (state_d == S_DRIVE && !lz_blank) begin
      an_d   = ~(4'b0001 << idx_d);
      bcd_d  = nib_d;
      dp_n_d = ~shadow_dp_d[idx_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_GAP;
      idx_q        <= 2'd0;
      cnt_q        <= '0;
      shadow_val_q <= 16'h0000;
      shadow_dp_q  <= 4'b0000;
      pend_val_q   <= 16'h0000;
      pend_dp_q    <= 4'b0000;
      load_pend_q  <= 1'b0;
      an_q         <= 4'b1111;
      bcd_q        <= 4'hF;
      dp_n_q       <= 1'b1;
      tick_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      load_pend_q  <= load_pend_d;
      an_q         <= an_d;
      bcd_q        <= bcd_d;
      dp_n_q       <= dp_n_d;
      tick_q       <= tick_d;
    end
  end

  assign load_pend  = load_pend_q;
  assign bcd        = bcd_q;
  assign an         = an_q;
  assign dp_n       = dp_n_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb/tb_seg7_scan_mux.sv - directed and random checks of seg7_scan_mux against a frame-position model
// Honours LEADING_ZERO_BLANK_EN the same way as the design build.
module tb_seg7_scan_mux;

  localparam int P     = 4;
  localparam int B     = 2;
  localparam int SLOT  = P + B;
  localparam int FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] val = 16'h0000;
  logic [3:0]  dpi = 4'b0000;
  logic        ld = 1'b0;

  logic        pend, dpn, tick;
  logic [3:0]  bcd, an;
  logic        pend2, dpn2, tick2;
  logic [3:0]  bcd2, an2;

  int vectors = 0;
  int miscompares = 0;

  int          pos;
  bit          started;
  bit          bnd;
  bit          nogap_armed;
  logic [15:0] m_shadow, m_pval;
  logic [3:0]  m_sdp, m_pdp;
  logic        m_pend;

  seg7_scan_mux #(.PRESCALE(P), .BLANK_CYC(B)) u_dut (
    .clk(clk), .rst_n(rst_n), .value(val), .dp_in(dpi), .load(ld),
    .load_pend(pend), .bcd(bcd), .an(an), .dp_n(dpn), .frame_tick(tick)
  );

  seg7_scan_mux #(.PRESCALE(P), .BLANK_CYC(0)) u_nogap (
    .clk(clk), .rst_n(rst_n), .value(val), .dp_in(dpi), .load(ld),
    .load_pend(pend2), .bcd(bcd2), .an(an2), .dp_n(dpn2), .frame_tick(tick2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_shadow = 16'h0000; m_sdp = 4'b0000;
    m_pval = 16'h0000;   m_pdp = 4'b0000; m_pend = 1'b0;
    pos = FRAME - 1; started = 1'b0; bnd = 1'b0;
  endtask

  task automatic check_outputs();
    int slot, off;
    bit lit, blank;
    logic [3:0] nib, e_an, e_bcd;
    logic e_dpn;
    slot  = pos / SLOT;
    off   = pos % SLOT;
    lit   = (off >= B);
    nib   = 4'((m_shadow >> (4 * slot)) & 16'h000F);
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (slot > 0 && (m_shadow >> (4 * slot)) == 16'h0000 && !m_sdp[slot]) blank = 1'b1;
`endif
    if (lit && !blank) begin
      e_an = ~(4'b0001 << slot); e_bcd = nib; e_dpn = ~m_sdp[slot];
    end else begin
      e_an = 4'b1111; e_bcd = 4'hF; e_dpn = 1'b1;
    end
    chk("an", {12'h0, an}, {12'h0, e_an});
    chk("bcd", {12'h0, bcd}, {12'h0, e_bcd});
    chk("dp_n", {15'h0, dpn}, {15'h0, e_dpn});
    chk("frame_tick", {15'h0, tick}, {15'h0, bnd});
    chk("load_pend", {15'h0, pend}, {15'h0, m_pend});
    if (nogap_armed)
      chk("nogap_one_anode", 16'($countones(~an2)), 16'd1);
  endtask

  task automatic step();
    @(posedge clk);
    bnd = started && (pos == FRAME - 1);
    if (bnd) begin
      if (ld) begin
        m_shadow = val; m_sdp = dpi;
      end else if (m_pend) begin
        m_shadow = m_pval; m_sdp = m_pdp;
      end
      m_pend = 1'b0;
    end else if (ld) begin
      m_pval = val; m_pdp = dpi; m_pend = 1'b1;
    end
    pos = (pos + 1) % FRAME;
    started = 1'b1;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic run_to(input int p);
    for (int k = 0; k < FRAME && pos != p; k++) step();
  endtask

  task automatic load1(input logic [15:0] v, input logic [3:0] d);
    ld = 1'b1; val = v; dpi = d;
    step();
    ld = 1'b0;
  endtask

  initial begin
    model_reset();
    nogap_armed = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_an", {12'h0, an}, 16'h000F);
    chk("reset_bcd", {12'h0, bcd}, 16'h000F);
    chk("reset_dp_n", {15'h0, dpn}, 16'h0001);
    chk("reset_tick", {15'h0, tick}, 16'h0000);
    chk("reset_pend", {15'h0, pend}, 16'h0000);
    rst_n = 1'b1;
    nogap_armed = 1'b1;

    // 1234 with dp on digit 2, loaded during the first frame
    run(3);
    load1(16'h1234, 4'b0100);
    run(2 * FRAME);

    // ABCD during digit 1 drive, then 1111 and 2222 in one frame
    run_to(SLOT + B);
    load1(16'hABCD, 4'b0000);
    run(FRAME);
    run_to(3);
    load1(16'h1111, 4'b0001);
    run(4);
    load1(16'h2222, 4'b0000);
    run(2 * FRAME);

    // load on the boundary edge itself
    run_to(FRAME - 1);
    load1(16'h5678, 4'b1010);
    run(FRAME + 3);

    // asynchronous reset mid-DRIVE discards a pending load
    run_to(B + 1);
    load1(16'h9999, 4'b1111);
    #2;
    rst_n = 1'b0;
    nogap_armed = 1'b0;
    #1;
    chk("async_an", {12'h0, an}, 16'h000F);
    chk("async_bcd", {12'h0, bcd}, 16'h000F);
    chk("async_dp_n", {15'h0, dpn}, 16'h0001);
    chk("async_tick", {15'h0, tick}, 16'h0000);
    chk("async_pend", {15'h0, pend}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    nogap_armed = 1'b1;
    model_reset();
    run(FRAME + 2);

    // randomized loads
    for (int i = 0; i < 200; i++) begin
      ld  = ($urandom_range(0, 9) == 0);
      val = 16'($urandom);
      dpi = 4'($urandom);
      step();
    end
    ld = 1'b0;
    run(FRAME);

    // leading-zero cases
    load1(16'h0050, 4'b0000);
    run(2 * FRAME);
    load1(16'h0000, 4'b0000);
    run(2 * FRAME);
    load1(16'h0000, 4'b1000);
    run(2 * FRAME);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
